serirq_module: RTL and testbench

- Downstream consumer of regs_module's irq_num / interrupt outputs.
- Serialises the TPM interrupt onto the LPC SERIRQ open-drain line, following the Serialized IRQ protocol in both continuous and quiet mode.
- Runs in the LPC clock domain, clk_i, the same clock as regs_module. No synchroniser is required.
- The top level builds the open-drain pad: SERIRQ = serirq_oe_o ? serirq_o : 'z'.

---
 rtl/serirq_pkg.sv | 38 +++
 rtl/serirq_module.sv | 215 +++++++++++++++++++++
 tb/tb_serirq_module.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/serirq_pkg.sv
// Shared constants for the SERIRQ serialiser: state and phase codes, default
// frame limits, stop-frame lengths and the slot numbers that must never be used.
package serirq_pkg;

  // Frame limit defaults
  localparam int unsigned DEF_MAX_SLOTS = 32;
  localparam int unsigned DEF_START_MIN = 4;
  localparam int unsigned DEF_START_MAX = 8;

  // Stop frame lengths selecting the next mode
  localparam int unsigned STOP_QUIET = 2;
  localparam int unsigned STOP_CONT  = 3;

  // Slots this device must never drive or request on
  localparam logic [3:0] SLOT_DISABLED = 4'd0;
  localparam logic [3:0] SLOT_SMI      = 4'd2;

  // Controller states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_QREQ    = 3'd1;
  localparam state_t ST_START   = 3'd2;
  localparam state_t ST_SLOT    = 3'd3;
  localparam state_t ST_STOP    = 3'd4;
  localparam state_t ST_WAIT_HI = 3'd5;

  // Phase of the clock being sampled inside a data frame
  typedef logic [1:0] phase_t;
  localparam phase_t PH_SAMPLE     = 2'd0;
  localparam phase_t PH_RECOVERY   = 2'd1;
  localparam phase_t PH_TURNAROUND = 2'd2;

  // A slot number is usable unless it is the disabled or SMI# slot
  function automatic logic slot_valid(input logic [3:0] slot);
    return (slot != SLOT_DISABLED) && (slot != SLOT_SMI);
  endfunction

endpackage

// File: rtl/serirq_module.sv
// Serialised IRQ slave: reports the TPM interrupt in its SERIRQ slot and
// follows the host between continuous and quiet mode via stop-frame length.
// Outputs are registered, so a value computed at one edge occupies the clock
// that ends at the next edge, where the host samples it.
module serirq_module
  import serirq_pkg::*;
#(
  parameter int unsigned MAX_SLOTS = DEF_MAX_SLOTS,
  parameter int unsigned START_MIN = DEF_START_MIN,
  parameter int unsigned START_MAX = DEF_START_MAX
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       serirq_i,
  output logic       serirq_o,
  output logic       serirq_oe_o,
  input  logic [3:0] irq_num_i,
  input  logic       interrupt_i,
  output logic       quiet_mode_o
);

  // Slot counter needs room for MAX_SLOTS plus an all-ones "before slot 0" value
  localparam int SLOT_W = $clog2(MAX_SLOTS + 1) + 1;
  // Low counter needs to reach START_MAX + 1 and saturate in long stop frames
  localparam int CNT_W  = $clog2(START_MAX + 2) + 1;

  localparam logic [SLOT_W-1:0] MAX_SLOTS_C  = SLOT_W'(MAX_SLOTS);
  localparam logic [CNT_W-1:0]  START_MIN_C  = CNT_W'(START_MIN);
  localparam logic [CNT_W-1:0]  START_MAX_C  = CNT_W'(START_MAX);
  localparam logic [CNT_W-1:0]  STOP_QUIET_C = CNT_W'(STOP_QUIET);
  localparam logic [CNT_W-1:0]  STOP_CONT_C  = CNT_W'(STOP_CONT);

  state_t              state_reg, state_next;
  phase_t              phase_reg, phase_next;
  logic [CNT_W-1:0]    low_cnt_reg, low_cnt_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic [3:0]          irq_lat_reg, irq_lat_next;
  logic                int_lat_reg, int_lat_next;
  logic                samp_low_reg, samp_low_next;
  logic                drove_reg, drove_next;
  logic                last_reported_reg, last_reported_next;
  logic                quiet_reg, quiet_next;
  logic                oe_reg, oe_next;
  logic                o_reg, o_next;

  logic [SLOT_W-1:0]   slot_inc;
  logic                own_now;
  logic                own_upcoming;
  logic                latched_valid;

  assign slot_inc      = slot_reg + SLOT_W'(1);
  assign latched_valid = slot_valid(irq_lat_reg);
  // The slot being sampled now, and the one that starts after this turnaround
  assign own_now       = latched_valid && (slot_reg == SLOT_W'(irq_lat_reg));
  assign own_upcoming  = latched_valid && (slot_inc == SLOT_W'(irq_lat_reg));

  assign serirq_o      = o_reg;
  assign serirq_oe_o   = oe_reg;
  assign quiet_mode_o  = quiet_reg;

  // Next-state and next-output decode; the line is released unless a branch drives it
  always_comb begin
    state_next         = state_reg;
    phase_next         = phase_reg;
    low_cnt_next       = low_cnt_reg;
    slot_next          = slot_reg;
    irq_lat_next       = irq_lat_reg;
    int_lat_next       = int_lat_reg;
    samp_low_next      = samp_low_reg;
    drove_next         = drove_reg;
    last_reported_next = last_reported_reg;
    quiet_next         = quiet_reg;
    oe_next            = 1'b0;
    o_next             = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A host start always wins over our own quiet-mode request
        if (!serirq_i) begin
          state_next   = ST_START;
          low_cnt_next = CNT_W'(1);
        end else if (quiet_reg && slot_valid(irq_num_i) &&
                     (interrupt_i != last_reported_reg)) begin
          state_next = ST_QREQ;
          oe_next    = 1'b1;
          o_next     = 1'b0;
        end
      end

      ST_QREQ: begin
        // Our single low clock is the first clock of the start frame
        state_next   = ST_START;
        low_cnt_next = CNT_W'(1);
      end

      ST_START: begin
        if (!serirq_i) begin
          if (low_cnt_reg >= START_MAX_C) begin
            state_next = ST_WAIT_HI;
          end else begin
            low_cnt_next = low_cnt_reg + CNT_W'(1);
          end
        end else if (low_cnt_reg >= START_MIN_C) begin
          // Recovery clock of the start frame; the next clock is turnaround
          state_next   = ST_SLOT;
          phase_next   = PH_TURNAROUND;
          slot_next    = '1;
          irq_lat_next = irq_num_i;
          int_lat_next = interrupt_i;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_SLOT: begin
        case (phase_reg)
          PH_TURNAROUND: begin
            if (slot_inc == MAX_SLOTS_C) begin
              state_next = ST_WAIT_HI;
            end else begin
              slot_next  = slot_inc;
              phase_next = PH_SAMPLE;
              drove_next = own_upcoming && int_lat_reg;
              if (own_upcoming && int_lat_reg) begin
                oe_next = 1'b1;
                o_next  = 1'b0;
              end
            end
          end

          PH_SAMPLE: begin
            phase_next    = PH_RECOVERY;
            samp_low_next = !serirq_i;
            if (own_now) begin
              // Actively restore the line high only if we pulled it low
              oe_next            = drove_reg;
              o_next             = drove_reg;
              last_reported_next = int_lat_reg;
            end
          end

          PH_RECOVERY: begin
            phase_next = PH_TURNAROUND;
            // Low through sample and recovery is the host's stop frame
            if (!own_now && samp_low_reg && !serirq_i) begin
              state_next   = ST_STOP;
              low_cnt_next = CNT_W'(2);
            end
          end

          default: begin
            state_next = ST_WAIT_HI;
          end
        endcase
      end

      ST_STOP: begin
        if (!serirq_i) begin
          if (low_cnt_reg != '1) begin
            low_cnt_next = low_cnt_reg + CNT_W'(1);
          end
        end else begin
          if (low_cnt_reg == STOP_QUIET_C) begin
            quiet_next = 1'b1;
          end else if (low_cnt_reg == STOP_CONT_C) begin
            quiet_next = 1'b0;
          end
          state_next = ST_IDLE;
        end
      end

      ST_WAIT_HI: begin
        if (serirq_i) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset releases the line without a clock edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg         <= ST_IDLE;
      phase_reg         <= PH_SAMPLE;
      low_cnt_reg       <= '0;
      slot_reg          <= '0;
      irq_lat_reg       <= '0;
      int_lat_reg       <= 1'b0;
      samp_low_reg      <= 1'b0;
      drove_reg         <= 1'b0;
      last_reported_reg <= 1'b0;
      quiet_reg         <= 1'b0;
      oe_reg            <= 1'b0;
      o_reg             <= 1'b0;
    end else begin
      state_reg         <= state_next;
      phase_reg         <= phase_next;
      low_cnt_reg       <= low_cnt_next;
      slot_reg          <= slot_next;
      irq_lat_reg       <= irq_lat_next;
      int_lat_reg       <= int_lat_next;
      samp_low_reg      <= samp_low_next;
      drove_reg         <= drove_next;
      last_reported_reg <= last_reported_next;
      quiet_reg         <= quiet_next;
      oe_reg            <= oe_next;
      o_reg             <= o_next;
    end
  end

endmodule

// File: tb/tb_serirq_module.sv
// Directed bench for serirq_module: a host model pulls the wired-AND SERIRQ
// line through start, data and stop frames while the bench checks the
// device's drive per clock and the resulting mode.
module tb_serirq_module;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       serirq_o;
  logic       serirq_oe_o;
  logic [3:0] irq_num_i;
  logic       interrupt_i;
  logic       quiet_mode_o;
  logic       host_n;
  logic       serirq_line;

  int n_cmp = 0;
  int n_err = 0;

  // Open-drain line: low if the host or the device pulls it low
  assign serirq_line = host_n & (serirq_oe_o ? serirq_o : 1'b1);

  always #5 clk_i = ~clk_i;

  serirq_module dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .serirq_i     (serirq_line),
    .serirq_o     (serirq_o),
    .serirq_oe_o  (serirq_oe_o),
    .irq_num_i    (irq_num_i),
    .interrupt_i  (interrupt_i),
    .quiet_mode_o (quiet_mode_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host-run SERIRQ cycle: start frame, nslots data frames, optional stop
  task automatic host_cycle(input string tag, input int start_len, input int nslots,
                            input int other_slot, input int new_irq, input int stop_len,
                            input int my_slot, input bit exp_drive, input bit exp_quiet);
    host_n = 1'b0;
    repeat (start_len) tick();
    host_n = 1'b1;
    tick();
    if (new_irq >= 0) irq_num_i = 4'(new_irq);
    tick();
    for (int k = 0; k < nslots; k++) begin
      bit mine;
      mine = exp_drive && (k == my_slot);
      if (k == other_slot) host_n = 1'b0;
      chk($sformatf("%s s%0d sample oe", tag, k), {7'd0, serirq_oe_o}, {7'd0, mine});
      if (mine) chk($sformatf("%s s%0d sample o", tag, k), {7'd0, serirq_o}, 8'd0);
      tick();
      host_n = 1'b1;
      chk($sformatf("%s s%0d recovery oe", tag, k), {7'd0, serirq_oe_o}, {7'd0, mine});
      if (mine) chk($sformatf("%s s%0d recovery o", tag, k), {7'd0, serirq_o}, 8'd1);
      tick();
      chk($sformatf("%s s%0d turnaround oe", tag, k), {7'd0, serirq_oe_o}, 8'd0);
      tick();
    end
    if (stop_len > 0) begin
      host_n = 1'b0;
      repeat (stop_len) tick();
      host_n = 1'b1;
      tick();
    end
    chk($sformatf("%s quiet_mode", tag), {7'd0, quiet_mode_o}, {7'd0, exp_quiet});
    $display("cycle %s: start=%0d slots=%0d stop=%0d quiet_mode=%0b", tag, start_len,
             nslots, stop_len, quiet_mode_o);
  endtask

  initial begin
    rst_n_i     = 1'b0;
    host_n      = 1'b1;
    irq_num_i   = 4'd5;
    interrupt_i = 1'b1;
    repeat (3) tick();
    chk("reset oe", {7'd0, serirq_oe_o}, 8'd0);
    chk("reset o", {7'd0, serirq_o}, 8'd0);
    chk("reset quiet", {7'd0, quiet_mode_o}, 8'd0);
    rst_n_i = 1'b1;
    tick();

    // Continuous mode, slot 5 asserted; irq_num changed after the latch
    host_cycle("A", 4, 6, -1, 3, 3, 5, 1'b1, 1'b0);
    irq_num_i = 4'd5;

    // Interrupt clear, another device in slot 3, stop of 2 enters quiet mode
    interrupt_i = 1'b0;
    host_cycle("B", 4, 6, 3, -1, 2, 5, 1'b0, 1'b1);

    // Quiet-mode request: exactly one low clock, then the host takes over
    tick();
    chk("quiet idle oe", {7'd0, serirq_oe_o}, 8'd0);
    interrupt_i = 1'b1;
    tick();
    chk("qreq oe", {7'd0, serirq_oe_o}, 8'd1);
    chk("qreq o", {7'd0, serirq_o}, 8'd0);
    host_n = 1'b0;
    tick();
    chk("qreq release oe", {7'd0, serirq_oe_o}, 8'd0);
    host_cycle("Q", 3, 6, -1, -1, 2, 5, 1'b1, 1'b1);

    // Invalid slots never request, even with a changed interrupt
    irq_num_i   = 4'd2;
    interrupt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle irq2 oe %0d", i), {7'd0, serirq_oe_o}, 8'd0);
    end
    irq_num_i = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle irq0 oe %0d", i), {7'd0, serirq_oe_o}, 8'd0);
    end
    irq_num_i   = 4'd5;
    interrupt_i = 1'b1;
    tick();
    chk("idle reported oe", {7'd0, serirq_oe_o}, 8'd0);

    // Stop of 3 returns to continuous; invalid slots never driven
    irq_num_i = 4'd0;
    host_cycle("I0", 4, 6, -1, -1, 3, 0, 1'b0, 1'b0);
    irq_num_i = 4'd2;
    host_cycle("I2", 4, 6, -1, -1, 3, 2, 1'b0, 1'b0);

    // Over-long start frame is ignored
    irq_num_i = 4'd5;
    host_cycle("L9", 9, 7, -1, -1, 3, 5, 1'b0, 1'b0);

    // Back to quiet, then a 33-slot cycle aborts before its 3-clock stop
    host_cycle("Q2", 4, 6, -1, -1, 2, 5, 1'b1, 1'b1);
    host_cycle("AB", 4, 33, -1, -1, 3, 5, 1'b1, 1'b1);

    // A 4-clock stop leaves the mode alone
    host_cycle("S4", 4, 6, -1, -1, 4, 5, 1'b1, 1'b1);

    // Reset during the driven slot-5 sample releases the line at once
    host_n = 1'b0;
    repeat (4) tick();
    host_n = 1'b1;
    tick();
    tick();
    repeat (15) tick();
    chk("pre-reset oe", {7'd0, serirq_oe_o}, 8'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async reset oe", {7'd0, serirq_oe_o}, 8'd0);
    chk("async reset o", {7'd0, serirq_o}, 8'd0);
    chk("async reset quiet", {7'd0, quiet_mode_o}, 8'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    host_cycle("PR", 4, 6, -1, -1, 3, 5, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
